genius_sequencer: RTL and testbench
===================================

Name: genius_sequencer

Overview:
Game controller for the Genius (Simon) board. Requests one colour per round from the random colour generator and appends it to an on-chip sequence memory. Replays the whole sequence on the LEDs, then checks the player's button presses against it. Sits between the RNG, the debounced button block and the LED drivers.

Parameters:
MAX_LEN, 16, maximum sequence length / winning level (2..64)
ON_CYCLES, 25000000, clocks each colour is lit during playback (>=1)
OFF_CYCLES, 12500000, dark clocks between playback colours (>=1)
TIMEOUT_CYCLES, 250000000, player inactivity limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; starts a new game from IDLE, WIN or LOSE
btn  in  4  debounced button pulses, one-hot, one cycle per press
rand_signal  in  4  RNG colour code: 0001, 0010, 0100 or 0011
rand_ready  in  1  RNG colour-valid flag
rand_enable  out  1  RNG run/hold control (low = RNG reseeds)
led  out  4  one-hot lamp drive
level  out  LW  current sequence length, LW = clog2(MAX_LEN+1)
busy  out  1  high in GEN, SHOW_ON and SHOW_OFF
win  out  1  high in WIN
game_over  out  1  high in LOSE

Behaviour:
- All outputs are registered.
- Reset: state=IDLE; led=0, level=0, rand_enable=0, busy=0, win=0, game_over=0. Memory contents are don't-care.
- rst asserted in any state returns the block to IDLE on the next edge.
- Colour decode to 2-bit index: 0001->0, 0010->1, 0100->2, 0011->3. Any other code maps to index 0.
- LED drive is one-hot by index: 0->0001, 1->0010, 2->0100, 3->1000.
- IDLE: on start, clear level, win and game_over; go to GEN.
- GEN:
  - rand_enable=1.
  - On the first cycle with rand_ready=1: write the decoded colour to seq[level], increment level, drop rand_enable to 0, set idx=0, load the timer with ON_CYCLES, go to SHOW_ON.
  - rand_ready is ignored while rand_enable is low.
- SHOW_ON: led=onehot(seq[idx]) for exactly ON_CYCLES clocks, then go to SHOW_OFF.
- SHOW_OFF: led=0 for exactly OFF_CYCLES clocks, then increment idx.
  - If idx==level: idx=0, go to WAIT_IN.
  - Otherwise go to SHOW_ON.
- Spacing guarantee: SHOW phases keep rand_enable low for at least 2 clocks between GEN visits, so the RNG's ready flag is cleared before the next request.
- WAIT_IN:
  - led=0. btn==0 is ignored; btn and start are evaluated every cycle.
  - Press equal to onehot(seq[idx]): increment idx.
    - If idx reaches level and level==MAX_LEN: go to WIN.
    - If idx reaches level and level<MAX_LEN: go to GEN.
    - Otherwise stay in WAIT_IN.
  - Wrong colour, or more than one bit set: go to LOSE.
- WIN: win=1, led=1111. Hold until start.
- LOSE: game_over=1, led=onehot(seq[idx]) to show the expected colour. Hold until start.
- start in WIN/LOSE: behaves as start in IDLE. start is ignored in GEN, SHOW_ON, SHOW_OFF and WAIT_IN.
- btn is ignored outside WAIT_IN.
- Latency from the last playback OFF period to accepting input is 1 clock.
- Counters:
  - idx and level are LW bits; the timer is wide enough for the largest of the cycle parameters.
  - No wrap-around is possible: level never exceeds MAX_LEN.

Optional Feature:
- Macro GENIUS_TIMEOUT_EN.
- Defined: WAIT_IN loads a counter with TIMEOUT_CYCLES on entry and after each correct press. Reaching zero with no press goes to LOSE.
- A press on the same cycle as expiry takes priority over the timeout.
- Undefined: no timeout counter exists; WAIT_IN waits indefinitely.

Test Plan:
- Use ON_CYCLES=3 and OFF_CYCLES=2 unless noted.
- Reset: rst held 2 cycles with random inputs -> all outputs 0, state IDLE; btn pulses produce no change.
- Start, RNG model returns 0100 two cycles after rand_enable rises -> rand_enable drops, level=1, led=0100 for 3 clocks, then 0 for 2 clocks, busy falls.
- Round 2: press btn=0100 in WAIT_IN, RNG returns 0011 -> level=2; playback shows 0100 then 1000, with 3/2-clock timing each.
- Wrong press: in round 2 press 0100 then 0001 -> game_over=1, led=1000. start -> game_over=0, level becomes 1 after the new GEN.
- Win: MAX_LEN=2, answer both rounds correctly -> win=1, led=1111, rand_enable stays 0; start restarts the game. A multi-bit press (0101) in WAIT_IN -> LOSE.
- GENIUS_TIMEOUT_EN with TIMEOUT_CYCLES=10: no press -> LOSE exactly 10 clocks after entering WAIT_IN. Without the macro: still WAIT_IN after 1000 clocks.

Source files
------------

// File: rtl/genius_sequencer.sv
// rtl/genius_sequencer.sv - Simon-style game sequencer: colour capture, playback and input checking
// Optional feature macro: GENIUS_TIMEOUT_EN (player inactivity timeout while waiting for input)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse, starts a new game from IDLE, WIN or LOSE
//   btn[3:0]          debounced one-hot button pulses
//   rand_signal[3:0]  RNG colour code; rand_ready = colour valid; rand_enable = RNG run/hold
//   led[3:0]          one-hot lamp drive (1111 on win)
//   level[LW-1:0]     current sequence length
//   busy, win, game_over  status flags
module genius_sequencer #(
    parameter int MAX_LEN        = 16,
    parameter int ON_CYCLES      = 25000000,
    parameter int OFF_CYCLES     = 12500000,
    parameter int TIMEOUT_CYCLES = 250000000,
    localparam int LW            = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    btn,
    input  logic [3:0]    rand_signal,
    input  logic          rand_ready,
    output logic          rand_enable,
    output logic [3:0]    led,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic          win,
    output logic          game_over
);
    // Memory is a power of two deep so the address slice exactly matches its index width.
    localparam int AW     = $clog2(MAX_LEN);
    localparam int DEPTH  = 1 << AW;
    localparam int T_MAX0 = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int T_MAX  = (T_MAX0 > TIMEOUT_CYCLES) ? T_MAX0 : TIMEOUT_CYCLES;
    localparam int TW     = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] T_ON    = TW'(ON_CYCLES);
    localparam logic [TW-1:0] T_OFF   = TW'(OFF_CYCLES);
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
`ifdef GENIUS_TIMEOUT_EN
    localparam logic [TW-1:0] T_TO    = TW'(TIMEOUT_CYCLES);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_WIN, S_LOSE
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] idx_q, idx_d, idx_inc;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    seq_q [DEPTH];
    logic          seq_we;
    logic [1:0]    seq_wdata;
    logic [1:0]    cur_col;
    logic [1:0]    nxt_col;
    logic [3:0]    led_q, led_d;
    logic          rand_enable_q, rand_enable_d;
    logic          busy_q, busy_d;
    logic          win_q, win_d;
    logic          game_over_q, game_over_d;

    function automatic logic [1:0] decode_col(input logic [3:0] code);
        case (code)
            4'b0001: decode_col = 2'd0;
            4'b0010: decode_col = 2'd1;
            4'b0100: decode_col = 2'd2;
            4'b0011: decode_col = 2'd3;
            default: decode_col = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] col);
        onehot = 4'b0001 << col;
    endfunction

    assign idx_inc   = idx_q + LW'(1);
    assign seq_wdata = decode_col(rand_signal);
    assign cur_col   = seq_q[idx_q[AW-1:0]];

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        seq_we  = 1'b0;
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    level_d = '0;
                    idx_d   = '0;
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                if (rand_ready) begin
                    seq_we  = 1'b1;
                    level_d = level_q + LW'(1);
                    idx_d   = '0;
                    timer_d = T_ON;
                    state_d = S_SHOW_ON;
                end
            end
            S_SHOW_ON: begin
                if (timer_q == T_ONE) begin
                    timer_d = T_OFF;
                    state_d = S_SHOW_OFF;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_SHOW_OFF: begin
                if (timer_q == T_ONE) begin
                    if (idx_inc == level_q) begin
                        idx_d   = '0;
                        state_d = S_WAIT_IN;
`ifdef GENIUS_TIMEOUT_EN
                        timer_d = T_TO;
`endif
                    end else begin
                        idx_d   = idx_inc;
                        timer_d = T_ON;
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_WAIT_IN: begin
                // A press always wins over a timeout expiring in the same cycle.
                if (btn != 4'b0000) begin
                    if (btn == onehot(cur_col)) begin
                        idx_d = idx_inc;
`ifdef GENIUS_TIMEOUT_EN
                        timer_d = T_TO;
`endif
                        if (idx_inc == level_q) begin
                            if (level_q == LEN_MAX) begin
                                state_d = S_WIN;
                            end else begin
                                idx_d   = '0;
                                state_d = S_GEN;
                            end
                        end
                    end else begin
                        // idx is left pointing at the colour the player missed.
                        state_d = S_LOSE;
                    end
`ifdef GENIUS_TIMEOUT_EN
                end else if (timer_q == T_ONE) begin
                    state_d = S_LOSE;
                end else begin
                    timer_d = timer_q - T_ONE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered; the colour read
    // bypasses the memory when the GEN write targets the slot shown first.
    always_comb begin
        nxt_col       = (seq_we && (level_q[AW-1:0] == idx_d[AW-1:0])) ? seq_wdata
                                                                       : seq_q[idx_d[AW-1:0]];
        led_d         = 4'b0000;
        rand_enable_d = 1'b0;
        busy_d        = 1'b0;
        win_d         = 1'b0;
        game_over_d   = 1'b0;
        case (state_d)
            S_GEN: begin
                rand_enable_d = 1'b1;
                busy_d        = 1'b1;
            end
            S_SHOW_ON: begin
                busy_d = 1'b1;
                led_d  = onehot(nxt_col);
            end
            S_SHOW_OFF: busy_d = 1'b1;
            S_WIN: begin
                win_d = 1'b1;
                led_d = 4'b1111;
            end
            S_LOSE: begin
                game_over_d = 1'b1;
                led_d       = onehot(nxt_col);
            end
            default: led_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            level_q       <= '0;
            idx_q         <= '0;
            timer_q       <= '0;
            led_q         <= 4'b0000;
            rand_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            win_q         <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            led_q         <= led_d;
            rand_enable_q <= rand_enable_d;
            busy_q        <= busy_d;
            win_q         <= win_d;
            game_over_q   <= game_over_d;
        end
    end

    always_ff @(posedge clk) begin
        if (seq_we) begin
            seq_q[level_q[AW-1:0]] <= seq_wdata;
        end
    end

    assign led         = led_q;
    assign level       = level_q;
    assign rand_enable = rand_enable_q;
    assign busy        = busy_q;
    assign win         = win_q;
    assign game_over   = game_over_q;
endmodule

// File: tb/tb_genius_sequencer.sv
// tb/tb_genius_sequencer.sv - self-checking bench for genius_sequencer
module tb_genius_sequencer;
    localparam int MAXL = 2;
    localparam int ONC  = 3;
    localparam int OFFC = 2;
    localparam int TOC  = 10;
    localparam int LW   = $clog2(MAXL + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    btn;
    logic [3:0]    rand_signal;
    logic          rand_ready;
    logic          rand_enable;
    logic [3:0]    led;
    logic [LW-1:0] level;
    logic          busy;
    logic          win;
    logic          game_over;

    int total = 0;
    int bad   = 0;

    int         model_seq[$];
    logic [3:0] exp_led[$];
    logic [3:0] obs_led[$];
    logic       obs_busy[$];

    genius_sequencer #(
        .MAX_LEN(MAXL), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn),
        .rand_signal(rand_signal), .rand_ready(rand_ready), .rand_enable(rand_enable),
        .led(led), .level(level), .busy(busy), .win(win), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic int col_of(input logic [3:0] code);
        case (code)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b0011: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] oh(input int c);
        logic [3:0] one = 4'b0001;
        return one << c;
    endfunction

    function automatic logic [3:0] rand_code();
        logic [3:0] table_v[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0011};
        int r = $urandom_range(0, 5);
        if (r < 4) return table_v[r];
        return 4'($urandom_range(0, 15));
    endfunction

    // Expected playback: each stored colour lit ONC clocks then dark OFFC clocks.
    task automatic build_expected();
        exp_led.delete();
        foreach (model_seq[i]) begin
            repeat (ONC) exp_led.push_back(oh(model_seq[i]));
            repeat (OFFC) exp_led.push_back(4'b0000);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] code);
        btn        = code;
        rand_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        btn        = 4'b0000;
        rand_ready = 1'b0;
    endtask

    // RNG model: answers one clock after it sees rand_enable high.
    task automatic rng_deliver(input logic [3:0] code, output bit ok);
        int n = 0;
        while (rand_enable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 20);
        @(negedge clk);
        rand_signal = code;
        rand_ready  = 1'b1;
        @(negedge clk);
        rand_ready  = 1'b0;
        rand_signal = 4'($urandom_range(0, 15));
        model_seq.push_back(col_of(code));
    endtask

    // Records the playback window while throwing ignored noise on start/btn/rand_ready.
    task automatic record_playback();
        obs_led.delete();
        obs_busy.delete();
        for (int k = 0; k < model_seq.size() * (ONC + OFFC); k++) begin
            obs_led.push_back(led);
            obs_busy.push_back(busy);
            start      = 1'($urandom_range(0, 1));
            btn        = 4'($urandom_range(0, 15));
            rand_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start      = 1'b0;
        btn        = 4'b0000;
        rand_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            start       = 1'($urandom_range(0, 1));
            btn         = 4'($urandom_range(0, 15));
            rand_signal = 4'($urandom_range(0, 15));
            rand_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        total++;
        if ({led, level, rand_enable, busy, win, game_over} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: led=%b level=%0d ren=%b busy=%b win=%b go=%b want all 0",
                     led, level, rand_enable, busy, win, game_over);
        end
        rst = 1'b0; start = 1'b0; btn = 4'b0000; rand_ready = 1'b0;
        @(negedge clk);
        press(oh($urandom_range(0, 3)));
        rand_ready = 1'b1;
        repeat (2) @(negedge clk);
        rand_ready = 1'b0;
        total++;
        if ({led, level, rand_enable, busy, win, game_over} !== '0) begin
            bad++;
            $display("FAIL idle_ignores_btn: led=%b level=%0d ren=%b busy=%b win=%b go=%b want all 0",
                     led, level, rand_enable, busy, win, game_over);
        end
    endtask

    task automatic test_first_round();
        bit ok;
        model_seq.delete();
        pulse_start();
        total++;
        if (rand_enable !== 1'b1 || busy !== 1'b1 || level !== LW'(0)) begin
            bad++;
            $display("FAIL start_gen: ren=%b busy=%b level=%0d want 1 1 0", rand_enable, busy, level);
        end
        rng_deliver(4'b0100, ok);
        total++;
        if (!ok || rand_enable !== 1'b0 || level !== LW'(1)) begin
            bad++;
            $display("FAIL gen_round1: ok=%0d ren=%b level=%0d want 1 0 1", ok, rand_enable, level);
        end
        record_playback();
        build_expected();
        foreach (exp_led[k]) begin
            total++;
            if (obs_led[k] !== exp_led[k] || obs_busy[k] !== 1'b1) begin
                bad++;
                $display("FAIL playback1[%0d]: led=%b busy=%b want %b 1", k, obs_led[k], obs_busy[k], exp_led[k]);
            end
        end
        total++;
        if (busy !== 1'b0 || led !== 4'b0000) begin
            bad++;
            $display("FAIL wait_entry: busy=%b led=%b want 0 0000", busy, led);
        end
    endtask

    task automatic test_round_two();
        bit ok;
        press(4'b0100);
        total++;
        if (rand_enable !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL round2_gen: ren=%b busy=%b want 1 1", rand_enable, busy);
        end
        rng_deliver(4'b0011, ok);
        total++;
        if (!ok || level !== LW'(2) || rand_enable !== 1'b0) begin
            bad++;
            $display("FAIL round2_level: ok=%0d level=%0d ren=%b want 1 2 0", ok, level, rand_enable);
        end
        record_playback();
        build_expected();
        foreach (exp_led[k]) begin
            total++;
            if (obs_led[k] !== exp_led[k] || obs_busy[k] !== 1'b1) begin
                bad++;
                $display("FAIL playback2[%0d]: led=%b busy=%b want %b 1", k, obs_led[k], obs_busy[k], exp_led[k]);
            end
        end
    endtask

    task automatic test_wrong_press();
        bit ok;
        press(4'b0100);
        total++;
        if (busy !== 1'b0 || game_over !== 1'b0 || led !== 4'b0000) begin
            bad++;
            $display("FAIL still_waiting: busy=%b go=%b led=%b want 0 0 0000", busy, game_over, led);
        end
        press(4'b0001);
        repeat (3) begin
            btn = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        btn = 4'b0000;
        total++;
        if (game_over !== 1'b1 || led !== 4'b1000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL lose_show: go=%b led=%b busy=%b want 1 1000 0", game_over, led, busy);
        end
        pulse_start();
        total++;
        if (game_over !== 1'b0 || level !== LW'(0) || rand_enable !== 1'b1) begin
            bad++;
            $display("FAIL restart_from_lose: go=%b level=%0d ren=%b want 0 0 1", game_over, level, rand_enable);
        end
        model_seq.delete();
        rng_deliver(rand_code(), ok);
        total++;
        if (!ok || level !== LW'(1)) begin
            bad++;
            $display("FAIL restart_level: ok=%0d level=%0d want 1 1", ok, level);
        end
        record_playback();
        build_expected();
        foreach (exp_led[k]) begin
            total++;
            if (obs_led[k] !== exp_led[k] || obs_busy[k] !== 1'b1) begin
                bad++;
                $display("FAIL playback_restart[%0d]: led=%b busy=%b want %b 1", k, obs_led[k], obs_busy[k], exp_led[k]);
            end
        end
    endtask

    task automatic test_win();
        bit ok;
        press(oh(model_seq[0]));
        rng_deliver(rand_code(), ok);
        total++;
        if (!ok || level !== LW'(2)) begin
            bad++;
            $display("FAIL win_round2: ok=%0d level=%0d want 1 2", ok, level);
        end
        record_playback();
        build_expected();
        foreach (exp_led[k]) begin
            total++;
            if (obs_led[k] !== exp_led[k] || obs_busy[k] !== 1'b1) begin
                bad++;
                $display("FAIL playback_win[%0d]: led=%b busy=%b want %b 1", k, obs_led[k], obs_busy[k], exp_led[k]);
            end
        end
        press(oh(model_seq[0]));
        press(oh(model_seq[1]));
        rand_ready = 1'b1;
        repeat (5) begin
            btn = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        rand_ready = 1'b0;
        btn = 4'b0000;
        total++;
        if (win !== 1'b1 || led !== 4'b1111 || rand_enable !== 1'b0 || level !== LW'(MAXL)) begin
            bad++;
            $display("FAIL win_hold: win=%b led=%b ren=%b level=%0d want 1 1111 0 %0d",
                     win, led, rand_enable, level, MAXL);
        end
        pulse_start();
        total++;
        if (win !== 1'b0 || level !== LW'(0) || rand_enable !== 1'b1) begin
            bad++;
            $display("FAIL restart_from_win: win=%b level=%0d ren=%b want 0 0 1", win, level, rand_enable);
        end
        model_seq.delete();
        rng_deliver(rand_code(), ok);
        record_playback();
        press(4'b0101);
        total++;
        if (game_over !== 1'b1 || led !== oh(model_seq[0])) begin
            bad++;
            $display("FAIL multibit_press: go=%b led=%b want 1 %b", game_over, led, oh(model_seq[0]));
        end
    endtask

    task automatic test_random_games();
        bit         ok, lost, won;
        int         wrong_pos;
        logic [3:0] wcode;
        for (int g = 0; g < 6; g++) begin
            pulse_start();
            total++;
            if (rand_enable !== 1'b1 || win !== 1'b0 || game_over !== 1'b0 || level !== LW'(0)) begin
                bad++;
                $display("FAIL rnd_start[%0d]: ren=%b win=%b go=%b level=%0d want 1 0 0 0",
                         g, rand_enable, win, game_over, level);
            end
            model_seq.delete();
            lost = 1'b0;
            won  = 1'b0;
            while (!lost && !won) begin
                rng_deliver(rand_code(), ok);
                total++;
                if (!ok || level !== LW'(model_seq.size())) begin
                    bad++;
                    lost = 1'b1;
                    $display("FAIL rnd_gen[%0d]: ok=%0d level=%0d want 1 %0d", g, ok, level, model_seq.size());
                end
                record_playback();
                build_expected();
                foreach (exp_led[k]) begin
                    total++;
                    if (obs_led[k] !== exp_led[k] || obs_busy[k] !== 1'b1) begin
                        bad++;
                        $display("FAIL rnd_playback[%0d][%0d]: led=%b busy=%b want %b 1",
                                 g, k, obs_led[k], obs_busy[k], exp_led[k]);
                    end
                end
                wrong_pos = $urandom_range(0, 3 * model_seq.size());
                for (int k = 0; k < model_seq.size() && !lost; k++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    if (k == wrong_pos) begin
                        do wcode = 4'($urandom_range(1, 15)); while (wcode == oh(model_seq[k]));
                        press(wcode);
                        lost = 1'b1;
                        total++;
                        if (game_over !== 1'b1 || led !== oh(model_seq[k])) begin
                            bad++;
                            $display("FAIL rnd_lose[%0d]: go=%b led=%b want 1 %b", g, game_over, led, oh(model_seq[k]));
                        end
                    end else begin
                        press(oh(model_seq[k]));
                        total++;
                        if (k < model_seq.size() - 1) begin
                            if (busy !== 1'b0 || game_over !== 1'b0 || win !== 1'b0) begin
                                bad++;
                                $display("FAIL rnd_wait[%0d]: busy=%b go=%b win=%b want 0 0 0", g, busy, game_over, win);
                            end
                        end else if (model_seq.size() == MAXL) begin
                            won = 1'b1;
                            if (win !== 1'b1 || led !== 4'b1111) begin
                                bad++;
                                $display("FAIL rnd_win[%0d]: win=%b led=%b want 1 1111", g, win, led);
                            end
                        end else if (rand_enable !== 1'b1 || busy !== 1'b1) begin
                            bad++;
                            $display("FAIL rnd_next[%0d]: ren=%b busy=%b want 1 1", g, rand_enable, busy);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        pulse_start();
        model_seq.delete();
        rng_deliver(rand_code(), ok);
        record_playback();
`ifdef GENIUS_TIMEOUT_EN
        begin
            int n = 0;
            while (game_over !== 1'b1 && n < TOC + 5) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (n != TOC) begin
                bad++;
                $display("FAIL timeout_cycles: lose after %0d clocks want %0d", n, TOC);
            end
        end
`else
        repeat (1000) @(negedge clk);
        total++;
        if (game_over !== 1'b0 || busy !== 1'b0 || win !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout: go=%b busy=%b win=%b want 0 0 0", game_over, busy, win);
        end
        press(oh(model_seq[0]));
        total++;
        if (rand_enable !== 1'b1) begin
            bad++;
            $display("FAIL late_press: ren=%b want 1", rand_enable);
        end
`endif
    endtask

    task automatic test_midgame_reset();
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        model_seq.delete();
        rng_deliver(4'b0010, ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({led, level, rand_enable, busy, win, game_over} !== '0) begin
            bad++;
            $display("FAIL midgame_reset: led=%b level=%0d ren=%b busy=%b want all 0", led, level, rand_enable, busy);
        end
        pulse_start();
        total++;
        if (rand_enable !== 1'b1 || level !== LW'(0)) begin
            bad++;
            $display("FAIL start_after_reset: ren=%b level=%0d want 1 0", rand_enable, level);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; btn = 4'b0000; rand_signal = 4'b0000; rand_ready = 1'b0;
        test_reset();
        test_first_round();
        test_round_two();
        test_wrong_press();
        test_win();
        test_random_games();
        test_timeout();
        test_midgame_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
